// File: rtl/sequence_detection.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sequence_detection                                              |
// | Purpose  : Serial bit-stream pattern detector. Samples one bit of A per    |
// |            rising clk edge and pulses Z for one cycle whenever the         |
// |            programmed PATTERN (MSB first) completes. Mismatches fall back  |
// |            to the longest matched prefix (KMP-style), with optional        |
// |            overlapping matches.                                            |
// | Ports    : clk       - rising-edge clock                                   |
// |            reset     - asynchronous, active-high reset                     |
// |            A         - serial data bit                                     |
// |            Z         - registered one-cycle detect pulse                   |
// |            det_count - 16-bit saturating match count (optional)            |
// | Options  : define SEQUENCE_DETECTION_COUNT_EN to add det_count.            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sequence_detection #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
  parameter int                 OVERLAP = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        A,
  output logic        Z
`ifdef SEQUENCE_DETECTION_COUNT_EN
  ,
  output logic [15:0] det_count
`endif
);

  // State k = number of leading pattern bits currently matched (0..PAT_LEN-1).
  localparam int               SW   = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;
  localparam int               NS   = 2 ** SW;
  localparam logic [SW-1:0]    LAST = SW'(PAT_LEN - 1);
  localparam logic             LAST_BIT = PATTERN[0];

  // Length of the longest suffix of (first k pattern bits, then bit a) that is
  // also a prefix of PATTERN, capped at PAT_LEN-1. For a matching bit with
  // k < PAT_LEN-1 this is simply k+1; for a completed match it is the longest
  // proper border, which is the overlap restart point.
  function automatic int border(input int k, input int a);
    logic [15:0] p;
    logic [15:0] t;
    int          lmax;
    int          best;
    int          pos;
    logic        ok;
    logic        sb;
    logic        pb;
    p    = 16'(PATTERN);
    lmax = (k + 1 < PAT_LEN) ? k + 1 : PAT_LEN - 1;
    best = 0;
    for (int l = 1; l <= 16; l++) begin
      if (l <= lmax) begin
        ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
          if (i < l) begin
            pos = k + 1 - l + i;
            if (pos < k) begin
              t  = p >> (PAT_LEN - 1 - pos);
              sb = t[0];
            end else begin
              sb = a[0];
            end
            t  = p >> (PAT_LEN - 1 - i);
            pb = t[0];
            if (sb != pb) ok = 1'b0;
          end
        end
        if (ok) best = l;
      end
    end
    return best;
  endfunction

  // Transition tables, fixed at elaboration. Unreachable encodings map to S0.
  logic [SW-1:0] nxt0 [0:NS-1];
  logic [SW-1:0] nxt1 [0:NS-1];

  for (genvar k = 0; k < NS; k++) begin : g_tbl
    if (k < PAT_LEN) begin : g_valid
      localparam int N0 = border(k, 0);
      localparam int N1 = border(k, 1);
      assign nxt0[k] = SW'(N0);
      assign nxt1[k] = SW'(N1);
    end else begin : g_unused
      assign nxt0[k] = '0;
      assign nxt1[k] = '0;
    end
  end

  logic [SW-1:0] state;
  logic [SW-1:0] next_state;
  logic          hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= '0;
      Z     <= 1'b0;
    end else begin
      state <= next_state;
      Z     <= hit;
    end
  end

  always_comb begin
    hit        = 1'b0;
    next_state = A ? nxt1[state] : nxt0[state];
    if ((state == LAST) && (A == LAST_BIT)) begin
      hit = 1'b1;
      // Non-overlapping mode discards any border and restarts empty.
      if (OVERLAP == 0) next_state = '0;
    end
  end

`ifdef SEQUENCE_DETECTION_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      det_count <= 16'd0;
    end else if (hit && (det_count != 16'hFFFF)) begin
      det_count <= det_count + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sequence_detection.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sequence_detection                                           |
// | Purpose  : Directed self-checking bench for sequence_detection. Drives a   |
// |            non-overlapping (default) and an overlapping instance from the  |
// |            same stimulus and compares Z against hand-computed vectors.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_sequence_detection;

  logic clk;
  logic reset;
  logic A;
  logic z_no;
  logic z_ov;
  int   checks;
  int   failures;

`ifdef SEQUENCE_DETECTION_COUNT_EN
  logic [15:0] cnt_no;
  logic [15:0] cnt_ov;
`endif

  sequence_detection #(.PAT_LEN(4), .PATTERN(4'b1101), .OVERLAP(0)) dut_no (
    .clk       (clk),
    .reset     (reset),
    .A         (A),
    .Z         (z_no)
`ifdef SEQUENCE_DETECTION_COUNT_EN
    ,
    .det_count (cnt_no)
`endif
  );

  sequence_detection #(.PAT_LEN(4), .PATTERN(4'b1101), .OVERLAP(1)) dut_ov (
    .clk       (clk),
    .reset     (reset),
    .A         (A),
    .Z         (z_ov)
`ifdef SEQUENCE_DETECTION_COUNT_EN
    ,
    .det_count (cnt_ov)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one bit, let it be sampled, then settle past the edge.
  task automatic step(input logic a);
    A = a;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    A     = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(i[0] ? 1'b0 : 1'b1);
      checks++;
      if (z_no !== 1'b0 || z_ov !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d z_no=%b z_ov=%b required 0", i, z_no, z_ov);
      end
    end
    reset = 1'b0;
    // Prefix 1,1,0 only: still no pulse after release.
    for (int i = 0; i < 3; i++) begin
      step(i == 2 ? 1'b0 : 1'b1);
      checks++;
      if (z_no !== 1'b0 || z_ov !== 1'b0) begin
        failures++;
        $display("FAIL reset_release cyc=%0d z_no=%b z_ov=%b required 0", i, z_no, z_ov);
      end
    end
  endtask

  task automatic test_basic_hit();
    logic [3:0] bits;
    logic [3:0] exp;
    bits = 4'b1101;
    exp  = 4'b0001;
    do_reset();
    for (int i = 3; i >= 0; i--) begin
      step(bits[i]);
      checks++;
      if (z_no !== exp[i]) begin
        failures++;
        $display("FAIL basic_hit edge=%0d Z=%b required %b", 4 - i, z_no, exp[i]);
      end
    end
    step(1'b0);
    checks++;
    if (z_no !== 1'b0) begin
      failures++;
      $display("FAIL basic_hit_drop Z=%b required 0", z_no);
    end
  endtask

  task automatic test_non_overlap_stream();
    logic [7:0] bits;
    logic [7:0] exp_no;
    logic [7:0] exp_ov;
    int         pulses;
    bits   = 8'b11011101;
    exp_no = 8'b00010001;
    exp_ov = 8'b00010001;
    pulses = 0;
    do_reset();
    for (int i = 7; i >= 0; i--) begin
      step(bits[i]);
      if (z_no === 1'b1) pulses++;
      checks++;
      if (z_no !== exp_no[i] || z_ov !== exp_ov[i]) begin
        failures++;
        $display("FAIL non_overlap edge=%0d z_no=%b z_ov=%b required %b/%b",
                 8 - i, z_no, z_ov, exp_no[i], exp_ov[i]);
      end
    end
    checks++;
    if (pulses != 2) begin
      failures++;
      $display("FAIL non_overlap_count pulses=%0d required 2", pulses);
    end
  endtask

  task automatic test_overlap();
    logic [6:0] bits;
    logic [6:0] exp_no;
    logic [6:0] exp_ov;
    bits   = 7'b1101101;
    exp_no = 7'b0001000;
    exp_ov = 7'b0001001;
    do_reset();
    for (int i = 6; i >= 0; i--) begin
      step(bits[i]);
      checks++;
      if (z_no !== exp_no[i] || z_ov !== exp_ov[i]) begin
        failures++;
        $display("FAIL overlap edge=%0d z_no=%b z_ov=%b required %b/%b",
                 7 - i, z_no, z_ov, exp_no[i], exp_ov[i]);
      end
    end
  endtask

  task automatic test_fallback();
    logic [5:0] bits;
    logic [5:0] exp;
    bits = 6'b111101;
    exp  = 6'b000001;
    do_reset();
    for (int i = 5; i >= 0; i--) begin
      step(bits[i]);
      checks++;
      if (z_no !== exp[i] || z_ov !== exp[i]) begin
        failures++;
        $display("FAIL fallback edge=%0d z_no=%b z_ov=%b required %b",
                 6 - i, z_no, z_ov, exp[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    step(1'b1);
    step(1'b1);
    step(1'b0);
    reset = 1'b1;
    step(1'b1);
    reset = 1'b0;
    step(1'b1);
    checks++;
    if (z_no !== 1'b0 || z_ov !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset z_no=%b z_ov=%b required 0", z_no, z_ov);
    end
    // Progress restarts from S0: 1101 now needed in full.
    step(1'b1);
    step(1'b0);
    checks++;
    if (z_no !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_restart Z=%b required 0", z_no);
    end
    step(1'b1);
    checks++;
    if (z_no !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_hit Z=%b required 1", z_no);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1'b1);
    step(1'b1);
    step(1'b0);
    step(1'b1);
    checks++;
    if (z_no !== 1'b1) begin
      failures++;
      $display("FAIL async_pre Z=%b required 1", z_no);
    end
    // Assert between edges: Z must clear without a clock edge.
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (z_no !== 1'b0 || z_ov !== 1'b0) begin
      failures++;
      $display("FAIL async_clear z_no=%b z_ov=%b required 0", z_no, z_ov);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

`ifdef SEQUENCE_DETECTION_COUNT_EN
  task automatic test_count();
    do_reset();
    for (int p = 0; p < 3; p++) begin
      step(1'b1);
      step(1'b1);
      step(1'b0);
      step(1'b1);
      step(1'b0);
    end
    checks++;
    if (cnt_no !== 16'd3) begin
      failures++;
      $display("FAIL count det_count=%0d required 3", cnt_no);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (cnt_no !== 16'd0) begin
      failures++;
      $display("FAIL count_reset det_count=%0d required 0", cnt_no);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    A        = 1'b0;
    #1;
    test_reset();
    test_basic_hit();
    test_non_overlap_stream();
    test_overlap();
    test_fallback();
    test_mid_reset();
    test_async_reset();
`ifdef SEQUENCE_DETECTION_COUNT_EN
    test_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
